// File: rtl/mesm6_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mesm6_bus_arbiter
//  Purpose  : Serialises MESM-6 ibus fetches and dbus accesses onto one
//             single-ported 48-bit memory; paired accesses complete together.
//  Revision : 1.0  initial release
// ============================================================================
module mesm6_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  // instruction bus
  input  logic        ibus_fetch,
  input  logic [14:0] ibus_addr,
  output logic [47:0] ibus_input,
  output logic        ibus_done,
  // data bus
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [14:0] dbus_addr,
  input  logic [47:0] dbus_output,
  output logic [47:0] dbus_input,
  output logic        dbus_done,
  // memory port
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [47:0] mem_wdata,
  input  logic [47:0] mem_rdata,
  input  logic        mem_ready,
  // status
  output logic        err_rw
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_I_ACC = 2'd1,
    ST_D_ACC = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_pair;
  logic        r_we;
  logic [14:0] r_daddr;
  logic        w_dreq;

  assign w_dreq = dbus_read | dbus_write;

  // mem_wdata doubles as the write-data latch: it is only loaded on leaving IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pair     <= 1'b0;
      r_we       <= 1'b0;
      r_daddr    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      ibus_done  <= 1'b0;
      dbus_done  <= 1'b0;
      ibus_input <= '0;
      dbus_input <= '0;
      err_rw     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          ibus_done <= 1'b0;
          dbus_done <= 1'b0;
          if (dbus_read && dbus_write)
            err_rw <= 1'b1;
          if (ibus_fetch || w_dreq) begin
            r_daddr   <= dbus_addr;
            r_we      <= dbus_write;
            mem_wdata <= dbus_output;
            mem_req   <= 1'b1;
            if (ibus_fetch) begin
              r_state  <= ST_I_ACC;
              r_pair   <= w_dreq;
              mem_we   <= 1'b0;
              mem_addr <= ibus_addr;
            end else begin
              r_state  <= ST_D_ACC;
              r_pair   <= 1'b0;
              mem_we   <= dbus_write;
              mem_addr <= dbus_addr;
            end
          end
        end

        ST_I_ACC: begin
          if (mem_ready) begin
            ibus_input <= mem_rdata;
            if (r_pair) begin
              r_state  <= ST_D_ACC;
              mem_we   <= r_we;
              mem_addr <= r_daddr;
            end else begin
              r_state   <= ST_RESP;
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              ibus_done <= 1'b1;
            end
          end
        end

        ST_D_ACC: begin
          if (mem_ready) begin
            if (!r_we)
              dbus_input <= mem_rdata;
            r_state   <= ST_RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            ibus_done <= r_pair;
            dbus_done <= 1'b1;
          end
        end

        ST_RESP: begin
          // requests seen here belong to the micro-op now completing
          ibus_done <= 1'b0;
          dbus_done <= 1'b0;
          r_pair    <= 1'b0;
          r_state   <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mesm6_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mesm6_bus_arbiter
//  Purpose  : Self-checking bench for mesm6_bus_arbiter with a transaction model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mesm6_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ibus_fetch;
  logic [14:0] ibus_addr;
  logic [47:0] ibus_input;
  logic        ibus_done;
  logic        dbus_read;
  logic        dbus_write;
  logic [14:0] dbus_addr;
  logic [47:0] dbus_output;
  logic [47:0] dbus_input;
  logic        dbus_done;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [47:0] mem_wdata;
  logic [47:0] mem_rdata;
  logic        mem_ready;
  logic        err_rw;

  int          errors = 0;
  int          checks = 0;
  logic [47:0] exp_i = '0;
  logic [47:0] exp_d = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  mesm6_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .ibus_fetch(ibus_fetch), .ibus_addr(ibus_addr), .ibus_input(ibus_input), .ibus_done(ibus_done),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
    .dbus_output(dbus_output), .dbus_input(dbus_input), .dbus_done(dbus_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err_rw(err_rw)
  );

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One micro-op: requests held until the done cycle, core inputs scrambled after edge 0.
  task automatic run_op(input string name, input bit f, input bit r, input bit w,
                        input logic [14:0] ia, input logic [14:0] da, input logic [47:0] wdat,
                        input logic [47:0] rd_i, input logic [47:0] rd_d,
                        input int wi, input int wdw, output int lat);
    bit          a_isi[2];
    bit          a_we[2];
    logic [14:0] a_addr[2];
    int          a_wait[2];
    logic [47:0] a_rd[2];
    int          n;
    int          cyc;
    n = 0;
    if (f) begin
      a_isi[n] = 1'b1; a_we[n] = 1'b0; a_addr[n] = ia; a_wait[n] = wi; a_rd[n] = rd_i; n++;
    end
    if (r || w) begin
      a_isi[n] = 1'b0; a_we[n] = w; a_addr[n] = da; a_wait[n] = wdw; a_rd[n] = rd_d; n++;
    end
    if (r && w) exp_err = 1'b1;

    ibus_fetch = f; dbus_read = r; dbus_write = w;
    ibus_addr = ia; dbus_addr = da; dbus_output = wdat;
    tick();
    ibus_addr = 15'($urandom); dbus_addr = 15'($urandom); dbus_output = rnd48();
    cyc = 1;
    for (int a = 0; a < n; a++) begin
      for (int k = 0; k <= a_wait[a]; k++) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== a_we[a] || mem_addr !== a_addr[a] ||
            (a_we[a] && mem_wdata !== wdat) || ibus_done !== 1'b0 || dbus_done !== 1'b0) begin
          errors++;
          $display("FAIL %s access%0d cyc%0d: req=%b we=%b addr=%o wdata=%h done=%b%b, expected req=1 we=%b addr=%o wdata=%h done=00",
                   name, a, cyc, mem_req, mem_we, mem_addr, mem_wdata, ibus_done, dbus_done,
                   a_we[a], a_addr[a], wdat);
        end
        mem_ready = (k == a_wait[a]);
        mem_rdata = (k == a_wait[a]) ? a_rd[a] : rnd48();
        tick();
        cyc++;
        mem_ready = 1'b0;
      end
      if (!a_we[a]) begin
        if (a_isi[a]) exp_i = a_rd[a];
        else          exp_d = a_rd[a];
      end
    end
    lat = cyc;
    checks++;
    if (ibus_done !== f || dbus_done !== (r | w) || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        ibus_input !== exp_i || dbus_input !== exp_d || err_rw !== exp_err) begin
      errors++;
      $display("FAIL %s resp: done=%b%b req=%b we=%b ii=%h di=%h err=%b, expected done=%b%b req=0 we=0 ii=%h di=%h err=%b",
               name, ibus_done, dbus_done, mem_req, mem_we, ibus_input, dbus_input, err_rw,
               f, r | w, exp_i, exp_d, exp_err);
    end
    ibus_fetch = 1'b0; dbus_read = 1'b0; dbus_write = 1'b0;
    tick();
    checks++;
    if (ibus_done !== 1'b0 || dbus_done !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s after_resp: done=%b%b req=%b, expected done=00 req=0",
               name, ibus_done, dbus_done, mem_req);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || ibus_done !== 1'b0 || dbus_done !== 1'b0 ||
        err_rw !== 1'b0 || ibus_input !== '0 || dbus_input !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset: req=%b we=%b done=%b%b err=%b ii=%h di=%h addr=%o wdata=%h, expected all 0",
               mem_req, mem_we, ibus_done, dbus_done, err_rw, ibus_input, dbus_input, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_single_fetch();
    int lat;
    run_op("single_fetch", 1, 0, 0, 15'o1234, 15'o0, 48'h0, 48'h0123456789AB, 48'h0, 0, 0, lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL single_fetch latency: got %0d, expected 2", lat);
    end
  endtask

  task automatic test_paired();
    int lat;
    run_op("paired", 1, 1, 0, 15'd5, 15'd7, rnd48(), rnd48(), rnd48(), 2, 2, lat);
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL paired latency: got %0d, expected 7", lat);
    end
  endtask

  task automatic test_write();
    int lat;
    run_op("write", 0, 0, 1, 15'o0, 15'o77777, 48'hFFFFFFFFFFFF, 48'h0, rnd48(), 0, 3, lat);
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL write latency: got %0d, expected 5", lat);
    end
  endtask

  task automatic test_back_to_back();
    int  dones = 0;
    int  reqs = 0;
    bit  prev_done = 1'b0;
    logic [47:0] pend = '0;
    ibus_fetch = 1'b1; ibus_addr = 15'o4444; mem_ready = 1'b1;
    for (int c = 0; c < 30 && dones < 3; c++) begin
      tick();
      if (mem_req) reqs++;
      if (ibus_done) begin
        dones++;
        checks++;
        if (prev_done || mem_req !== 1'b0 || dbus_done !== 1'b0 || ibus_input !== pend) begin
          errors++;
          $display("FAIL back_to_back done%0d: prev_done=%b req=%b ddone=%b ii=%h, expected prev_done=0 req=0 ddone=0 ii=%h",
                   dones, prev_done, mem_req, dbus_done, ibus_input, pend);
        end
      end
      if (mem_req) begin
        checks++;
        if (mem_addr !== 15'o4444 || mem_we !== 1'b0) begin
          errors++;
          $display("FAIL back_to_back addr: addr=%o we=%b, expected addr=4444 we=0", mem_addr, mem_we);
        end
      end
      prev_done = ibus_done;
      mem_rdata = rnd48();
      if (mem_req) pend = mem_rdata;
      if (dones == 3) ibus_fetch = 1'b0;
    end
    ibus_fetch = 1'b0;
    exp_i = pend;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_req) reqs++;
      if (ibus_done) dones++;
    end
    mem_ready = 1'b0;
    checks++;
    if (dones !== 3 || reqs !== 3) begin
      errors++;
      $display("FAIL back_to_back count: dones=%0d reqs=%0d, expected dones=3 reqs=3", dones, reqs);
    end
  endtask

  task automatic test_random(input int n_ops);
    int lat;
    int exp_lat;
    bit f, r, w;
    int kind, wi, wdw;
    for (int i = 0; i < n_ops; i++) begin
      f = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 6);
      r = (kind == 1 || kind == 2 || kind == 6);
      w = (kind == 3 || kind == 4 || kind == 6);
      if (!f && !r && !w) f = 1'b1;
      wi = $urandom_range(0, 3);
      wdw = $urandom_range(0, 3);
      run_op("random", f, r, w, 15'($urandom), 15'($urandom), rnd48(), rnd48(), rnd48(), wi, wdw, lat);
      exp_lat = 1 + (f ? wi + 1 : 0) + ((r || w) ? wdw + 1 : 0);
      checks++;
      if (lat !== exp_lat) begin
        errors++;
        $display("FAIL random latency op%0d: got %0d, expected %0d", i, lat, exp_lat);
      end
    end
  endtask

  task automatic test_rw_err();
    int lat;
    run_op("rw_err", 0, 1, 1, 15'o0, 15'o1357, 48'h123456ABCDEF, 48'h0, rnd48(), 1, 0, lat);
    run_op("rw_err_later_read", 0, 1, 0, 15'o0, 15'o2, 48'h0, 48'h0, rnd48(), 0, 1, lat);
    run_op("rw_err_later_fetch", 1, 0, 0, 15'o3, 15'o0, 48'h0, rnd48(), 48'h0, 2, 0, lat);
  endtask

  task automatic test_reset_mid();
    int lat;
    ibus_fetch = 1'b1; ibus_addr = 15'o321; mem_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 15'o321) begin
      errors++;
      $display("FAIL reset_mid pre: req=%b addr=%o, expected req=1 addr=321", mem_req, mem_addr);
    end
    reset = 1'b1; ibus_fetch = 1'b0;
    tick();
    reset = 1'b0;
    exp_i = '0; exp_d = '0; exp_err = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (mem_req !== 1'b0 || ibus_done !== 1'b0 || dbus_done !== 1'b0 || err_rw !== 1'b0 || ibus_input !== '0) begin
        errors++;
        $display("FAIL reset_mid post%0d: req=%b done=%b%b err=%b ii=%h, expected req=0 done=00 err=0 ii=0",
                 c, mem_req, ibus_done, dbus_done, err_rw, ibus_input);
      end
      tick();
    end
    run_op("reset_mid_fresh", 1, 0, 0, 15'o321, 15'o0, 48'h0, rnd48(), 48'h0, 1, 0, lat);
  endtask

  initial begin
    reset = 1'b1;
    ibus_fetch = 1'b0; ibus_addr = '0;
    dbus_read = 1'b0; dbus_write = 1'b0; dbus_addr = '0; dbus_output = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_fetch();
    test_paired();
    test_write();
    test_back_to_back();
    test_random(40);
    test_rw_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mesm6_bus_arbiter.md
# mesm6_bus_arbiter

Shares one single-ported 48-bit memory between the MESM-6 core's instruction bus (ibus) and data bus (dbus). It accepts level requests from both buses, serialises them onto the memory port, buffers read data, and returns completion so that a micro-op issuing both a fetch and a data access sees both `done` strobes in the same cycle. It sits between `mesm6_core` and the memory model or controller.

## Interface
- No parameters. Address width is fixed at 15; data width at 48.
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- ibus_fetch  in  1  fetch request (level, held while core stalls)
- ibus_addr  in  15  fetch word address
- ibus_input  out  48  fetched word (registered)
- ibus_done  out  1  fetch complete strobe
- dbus_read  in  1  data read request (level)
- dbus_write  in  1  data write request (level)
- dbus_addr  in  15  data address
- dbus_output  in  48  write data from core
- dbus_input  out  48  read data (registered)
- dbus_done  out  1  data access complete strobe
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  15  memory address
- mem_wdata  out  48  memory write data
- mem_rdata  in  48  memory read data, valid when mem_ready
- mem_ready  in  1  memory accepts or completes the access this cycle
- err_rw  out  1  sticky: dbus_read and dbus_write were seen high together

## Operation
- States: IDLE, I_ACC, D_ACC, RESP.
- IDLE samples the requests on each rising edge:
  - ibus_fetch only → I_ACC.
  - dbus only → D_ACC.
  - Both → I_ACC with `pair` = 1.
  - None → stay in IDLE.
- On leaving IDLE, the block latches the ibus address, dbus address, dbus_output and the write flag. Core input changes after that point are ignored until IDLE is re-entered.
- I_ACC:
  - mem_req=1, mem_we=0, mem_addr=latched ibus_addr.
  - On mem_ready: ibus_input ← mem_rdata. Go to D_ACC if pair=1, else RESP.
- D_ACC:
  - mem_req=1, mem_we=latched write, mem_addr=latched dbus_addr, mem_wdata=latched data.
  - On mem_ready: for a read, dbus_input ← mem_rdata. Go to RESP.
- RESP, one cycle:
  - ibus_done=1 if a fetch was served; dbus_done=1 if a data access was served. A paired access raises both in this same cycle.
  - Requests are ignored in RESP; they belong to the micro-op just completing.
  - Clear pair; go to IDLE.
- dbus_read and dbus_write both high in IDLE: treat as a write and set err_rw=1. err_rw clears only on reset.
- ibus_input and dbus_input hold their value until the next capture of the same bus. A data write does not alter dbus_input.
- Outside I_ACC and D_ACC: mem_req=0, mem_we=0. mem_addr and mem_wdata are don't-care but driven from the latches.

## Timing
- Reset values:
  - state IDLE, pair 0.
  - mem_req, mem_we, ibus_done, dbus_done, err_rw = 0.
  - ibus_input, dbus_input, mem_addr, mem_wdata = 0.
- Reset mid-access abandons the transaction: mem_req drops in the cycle after the reset edge, and no done is issued. The memory must tolerate a request withdrawn before mem_ready.
- Single access:
  - Request sampled at edge 0; mem_req high in cycle 1.
  - If mem_ready is high in cycle 1, done is high in cycle 2 (minimum latency 2).
  - Each wait cycle of mem_ready adds 1.
- Paired access: minimum latency 3 (I_ACC, D_ACC, RESP).
- mem_addr, mem_we and mem_wdata are stable for every cycle mem_req is high.
- Done strobes last exactly one cycle. A request still high in the cycle after RESP is a new request.

## Test plan
- Single fetch, mem_ready tied to 1, ibus_addr=0o1234, mem_rdata=0x0123456789AB → mem_req in cycle 1 with mem_addr=0o1234; ibus_done in cycle 2; ibus_input=0x0123456789AB; dbus_done stays 0.
- Paired access: fetch addr 5, dbus_read addr 7, mem_ready delayed 2 cycles per access → addr 5 then addr 7 on the memory port; ibus_done and dbus_done both high in the same single cycle (cycle 7); each bus receives its own data.
- Data write: addr 0o77777, data 0xFFFFFFFFFFFF, core changes dbus_output after edge 0 → mem_we=1 and mem_wdata=0xFFFFFFFFFFFF stable until mem_ready; dbus_input unchanged.
- Back-to-back fetches held continuously high for 3 micro-ops → exactly 3 ibus_done pulses, each separated by at least one non-done cycle; no duplicated memory access during RESP.
- Reset asserted in I_ACC while mem_ready=0 → next cycle mem_req=0, state IDLE, no done pulse; a fresh fetch afterwards completes normally.
- dbus_read=dbus_write=1 → write issued, err_rw=1 and remains 1 through later accesses until reset.
